// File: rtl/tx_scrambler_if.sv
// Block interface between the TX encoder, the 64b/66b scrambler and the downstream lane logic.
// The i_test_mode signal exists only when PCS_TX_SCR_PRBS31_EN is defined.
`timescale 1ns/1ps
interface tx_scrambler_if #(
    parameter int NB_DATA_CODED = 66
);
    logic                     i_enable;
    logic                     i_valid;
    logic                     i_bypass;
    logic [NB_DATA_CODED-1:0] i_tx_coded;
    logic [NB_DATA_CODED-1:0] o_tx_scrambled;
    logic                     o_valid;
`ifdef PCS_TX_SCR_PRBS31_EN
    logic                     i_test_mode;
`endif

    modport master (
        output i_enable, i_valid, i_bypass, i_tx_coded,
`ifdef PCS_TX_SCR_PRBS31_EN
        output i_test_mode,
`endif
        input  o_tx_scrambled, o_valid
    );

    modport slave (
        input  i_enable, i_valid, i_bypass, i_tx_coded,
`ifdef PCS_TX_SCR_PRBS31_EN
        input  i_test_mode,
`endif
        output o_tx_scrambled, o_valid
    );
endinterface

// File: rtl/tx_scrambler.sv
// Self-synchronous 64b/66b payload scrambler, G(x) = 1 + x^39 + x^58; sync header passes through.
// Optional PRBS31 test-pattern generator is compiled in when PCS_TX_SCR_PRBS31_EN is defined.
`timescale 1ns/1ps
module tx_scrambler #(
    parameter int                     NB_DATA_CODED = 66,
    parameter int                     NB_SCR_STATE  = 58,
    parameter logic [NB_SCR_STATE-1:0] SCR_SEED     = {NB_SCR_STATE{1'b1}}
) (
    input logic          i_clock,
    input logic          i_reset,
    tx_scrambler_if.slave bus
);
    localparam int NB_PAYLOAD = NB_DATA_CODED - 2;
    localparam int NB_SEQ     = NB_SCR_STATE + NB_PAYLOAD;

    logic [NB_SCR_STATE-1:0]  scr_state;
    logic [NB_SCR_STATE-1:0]  scr_state_next;
    logic [NB_PAYLOAD-1:0]    scr_payload;
    logic [NB_DATA_CODED-1:0] tx_scrambled_q;
    logic                     valid_q;
    logic                     acc;

    // Bit sequence in time order: history (oldest first) followed by the new block, bit 0 first.
    function automatic logic [NB_PAYLOAD-1:0] scramble(
        input logic [NB_PAYLOAD-1:0]   d,
        input logic [NB_SCR_STATE-1:0] hist
    );
        logic [NB_SEQ-1:0] seq;
        seq = '0;
        for (int j = 0; j < NB_SCR_STATE; j++) begin
            seq[j] = hist[NB_SCR_STATE-1-j];
        end
        for (int i = 0; i < NB_PAYLOAD; i++) begin
            seq[NB_SCR_STATE+i] = d[i] ^ seq[NB_SCR_STATE+i-39] ^ seq[i];
        end
        return seq[NB_SEQ-1:NB_SCR_STATE];
    endfunction

    assign acc = bus.i_enable & bus.i_valid;

    always_comb begin
        scr_payload    = scramble(bus.i_tx_coded[NB_PAYLOAD-1:0], scr_state);
        scr_state_next = '0;
        for (int k = 0; k < NB_SCR_STATE; k++) begin
            scr_state_next[k] = scr_payload[NB_PAYLOAD-1-k];
        end
    end

`ifdef PCS_TX_SCR_PRBS31_EN
    logic [30:0]              prbs_state;
    logic [30:0]              prbs_state_next;
    logic [NB_DATA_CODED-1:0] prbs_bits;

    // PRBS31 (x^31 + x^28 + 1), one full coded block of bits per accepted test-mode block.
    always_comb begin
        prbs_state_next = prbs_state;
        prbs_bits       = '0;
        for (int i = 0; i < NB_DATA_CODED; i++) begin
            prbs_bits[i]    = prbs_state_next[30] ^ prbs_state_next[27];
            prbs_state_next = {prbs_state_next[29:0], prbs_bits[i]};
        end
    end
`endif

    always_ff @(posedge i_clock or negedge i_reset) begin
        if (!i_reset) begin
            tx_scrambled_q <= '0;
            valid_q        <= 1'b0;
            scr_state      <= SCR_SEED;
`ifdef PCS_TX_SCR_PRBS31_EN
            prbs_state     <= '1;
`endif
        end else begin
            valid_q <= acc;
`ifdef PCS_TX_SCR_PRBS31_EN
            if (acc && bus.i_test_mode) begin
                tx_scrambled_q <= prbs_bits;
                prbs_state     <= prbs_state_next;
            end else
`endif
            if (acc) begin
                // History always advances with the scrambled bits so leaving bypass needs no resync.
                tx_scrambled_q <= {bus.i_tx_coded[NB_DATA_CODED-1:NB_PAYLOAD],
                                   bus.i_bypass ? bus.i_tx_coded[NB_PAYLOAD-1:0] : scr_payload};
                scr_state      <= scr_state_next;
            end
        end
    end

    assign bus.o_tx_scrambled = tx_scrambled_q;
    assign bus.o_valid        = valid_q;
endmodule
